lighthouse_emulator: RTL



---
 rtl/lighthouse_emulator_if.sv | 13 +
 rtl/lighthouse_emulator.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/lighthouse_emulator_if.sv
// Avalon-MM slave bus for the lighthouse emulator register file.
// Zero wait states: readdata is a combinational mux and waitrequest is always low.
interface lighthouse_emulator_if;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (output address, write, writedata, read, input readdata, waitrequest);
    modport slave  (input address, write, writedata, read, output readdata, waitrequest);
endinterface

// File: rtl/lighthouse_emulator.sv
// Lighthouse base-station emulator: length-coded sync flash + sweep pulse per cycle on sensor_o (one clock after the tick counter).
// Never stalls the bus; LIGHTHOUSE_EMULATOR_OOTX_EN adds OOTX payload serialisation through the sync data bit.
module lighthouse_emulator #(
    parameter int CYCLE_TICKS = 416667,
    parameter int SYNC_BASE   = 3125,
    parameter int SYNC_STEP   = 521,
    parameter int SWEEP_WIDTH = 500
) (
    input  logic                 clock,
    input  logic                 reset,
    lighthouse_emulator_if.slave bus,
    output logic                 sensor_o
);

    typedef enum logic [2:0] {IDLE, SYNC, GAP, SWEEP, TAIL} state_t;
    state_t state, state_nxt;

    logic [19:0] t, t_inc;
    logic [31:0] t_ext;
    logic        wrap, start;
    logic        ctrl_en, ctrl_skip;
    logic [19:0] sweep0, sweep1;
    logic        axis, new_axis;
    logic [15:0] cycle_cnt;
    logic [31:0] lat_len, lat_beg, lat_end;
    logic        lat_ok;
    logic        data_bit;
    logic [2:0]  code;
    logic [31:0] new_len, new_beg, new_end;
    logic        new_ok;
    logic        busy, overflow;
    logic [31:0] ootx_rd;
    logic        unused_bits;

    assign t_inc    = t + 20'd1;
    assign t_ext    = {12'd0, t_inc};
    assign wrap     = (state != IDLE) && (t == 20'(CYCLE_TICKS - 1));
    assign start    = ctrl_en && ((state == IDLE) || wrap);
    assign new_axis = (state == IDLE) ? 1'b0 : ~axis;

    // Parameters of the cycle about to begin, captured when the counter (re)enters tick 0.
    assign code    = {ctrl_skip, data_bit, new_axis};
    assign new_len = 32'(SYNC_BASE) + 32'(SYNC_STEP) * {29'd0, code};
    assign new_beg = {12'd0, (new_axis ? sweep1 : sweep0)};
    assign new_end = new_beg + 32'(SWEEP_WIDTH);
    assign new_ok  = (new_beg > new_len) && (new_end <= 32'(CYCLE_TICKS));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ctrl_en) state_nxt = SYNC;
            default: begin
                if (wrap)                  state_nxt = ctrl_en ? SYNC : IDLE;
                else if (t_ext < lat_len)  state_nxt = SYNC;
                else if (!lat_ok)          state_nxt = (state == SYNC) ? GAP : TAIL;
                else if (t_ext < lat_beg)  state_nxt = GAP;
                else if (t_ext < lat_end)  state_nxt = SWEEP;
                else                       state_nxt = TAIL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            t         <= 20'd0;
            sensor_o  <= 1'b0;
            ctrl_en   <= 1'b0;
            ctrl_skip <= 1'b0;
            sweep0    <= 20'd0;
            sweep1    <= 20'd0;
            axis      <= 1'b0;
            cycle_cnt <= 16'd0;
            lat_len   <= 32'd0;
            lat_beg   <= 32'd0;
            lat_end   <= 32'd0;
            lat_ok    <= 1'b0;
        end else begin
            state    <= state_nxt;
            t        <= ((state == IDLE) || wrap) ? 20'd0 : t_inc;
            sensor_o <= (state == SYNC) || (state == SWEEP);
            if (wrap) cycle_cnt <= cycle_cnt + 16'd1;
            if (start) begin
                axis    <= new_axis;
                lat_len <= new_len;
                lat_beg <= new_beg;
                lat_end <= new_end;
                lat_ok  <= new_ok;
            end
            if (bus.write) begin
                case (bus.address)
                    3'd0:    {ctrl_skip, ctrl_en} <= bus.writedata[1:0];
                    3'd1:    sweep0 <= bus.writedata[19:0];
                    3'd2:    sweep1 <= bus.writedata[19:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef LIGHTHOUSE_EMULATOR_OOTX_EN
    logic [31:0] shreg;
    logic [5:0]  bit_cnt;
    logic        stuff;

    // Positions 16 and 33 of the 34-bit frame are stuffing ones; the shift register holds still there.
    assign stuff    = (bit_cnt == 6'd16) || (bit_cnt == 6'd33);
    assign data_bit = busy && (stuff || shreg[31]);
    assign ootx_rd  = shreg;

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg    <= 32'd0;
            bit_cnt  <= 6'd0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (bus.write && (bus.address == 3'd3) && !busy) begin
                shreg   <= bus.writedata;
                bit_cnt <= 6'd0;
                busy    <= 1'b1;
            end else if (start && busy) begin
                if (!stuff) shreg <= shreg << 1;
                bit_cnt <= bit_cnt + 6'd1;
                if (bit_cnt == 6'd33) busy <= 1'b0;
            end
            if (bus.write && (bus.address == 3'd3) && busy)
                overflow <= 1'b1;
            else if (bus.write && (bus.address == 3'd4) && bus.writedata[1])
                overflow <= 1'b0;
        end
    end
`else
    assign data_bit = 1'b0;
    assign busy     = 1'b0;
    assign overflow = 1'b0;
    assign ootx_rd  = 32'd0;
`endif

    always_comb begin
        bus.readdata = 32'hDEAD_BEEF;
        case (bus.address)
            3'd0:    bus.readdata = {30'd0, ctrl_skip, ctrl_en};
            3'd1:    bus.readdata = {12'd0, sweep0};
            3'd2:    bus.readdata = {12'd0, sweep1};
            3'd3:    bus.readdata = ootx_rd;
            3'd4:    bus.readdata = {cycle_cnt, 13'd0, axis, overflow, busy};
            default: ;
        endcase
    end

    assign bus.waitrequest = 1'b0;
    assign unused_bits     = &{1'b0, bus.read, bus.writedata};

endmodule
